// File: rtl/alu_seq.sv
// alu_seq -- command sequencer for the shared 8-bit ALU (ALU8).
//
// It accepts one operation at a time over a valid/ready command port and
// drives the single ALU8 instance it owns. Ops 0-7 go straight to ALU8 and
// take one execute cycle. MUL is repeated ADD. NEG is computed as 0 - a.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready high only in IDLE)
//   cmd_op[3:0]           0-7 ALU8 ops, 8 MUL, 9 NEG, 10-15 illegal
//   cmd_a, cmd_b [7:0]    operands
//   rsp_valid/rsp_ready   response handshake (rsp_valid high only in DONE)
//   rsp_result[7:0]       result byte
//   rsp_flags[3:0]        {n, z, v, c}
//   rsp_err               illegal opcode
//   busy                  high in every state except IDLE

package alu8_pkg;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_INC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_DEC = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_NOT = 3'd7
  } alu_op_e;

  typedef enum logic [3:0] {
    OPC_MUL = 4'd8,
    OPC_NEG = 4'd9
  } seq_op_e;
endpackage

// ALU8 -- combinational 8-bit ALU.
//   a, b [7:0]  operands
//   op          operation (alu_op_e)
//   y [7:0]     result
//   n, z, v, c  negative, zero, signed overflow, carry
// ADD/INC: c is the carry out. SUB/DEC: c is the borrow (a < subtrahend).
// Logic ops clear v and c.
module ALU8
  import alu8_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  alu_op_e    op,
  output logic [7:0] y,
  output logic       n,
  output logic       z,
  output logic       v,
  output logic       c
);

  logic [8:0] sum;

  always_comb begin
    sum = '0;
    y   = '0;
    v   = 1'b0;
    c   = 1'b0;
    case (op)
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[7:0];
        c   = sum[8];
        v   = (a[7] == b[7]) && (y[7] != a[7]);
      end
      ALU_INC: begin
        sum = {1'b0, a} + 9'd1;
        y   = sum[7:0];
        c   = sum[8];
        v   = (a == 8'h7F);
      end
      ALU_SUB: begin
        y = a - b;
        c = (a < b);
        v = (a[7] != b[7]) && (y[7] != a[7]);
      end
      ALU_DEC: begin
        y = a - 8'd1;
        c = (a == 8'h00);
        v = (a == 8'h80);
      end
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOT: y = ~a;
      default: y = '0;
    endcase
    n = y[7];
    z = (y == 8'h00);
  end

endmodule

module alu_seq
  import alu8_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic [3:0] rsp_flags,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e     state, state_nxt;

  logic [3:0] op_r;
  logic [7:0] a_r, b_r;
  logic [7:0] acc, cnt;
  logic       csticky;
  logic       mul_first;
  logic [7:0] res_r;
  logic [3:0] flags_r;
  logic       err_r;

  logic [7:0] alu_a, alu_b, alu_y;
  alu_op_e    alu_op;
  logic       alu_n, alu_z, alu_v, alu_c;

  logic       cmd_legal_exec;
  assign cmd_legal_exec = (cmd_op <= 4'd7) || (cmd_op == OPC_NEG);

  ALU8 u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y),
    .n  (alu_n),
    .z  (alu_z),
    .v  (alu_v),
    .c  (alu_c)
  );

  // ALU operand/operation mux; MUL accumulates acc + a_r.
  always_comb begin
    alu_a  = acc;
    alu_b  = a_r;
    alu_op = ALU_ADD;
    if (state == EXEC) begin
      if (op_r == OPC_NEG) begin
        alu_a  = '0;
        alu_b  = a_r;
        alu_op = ALU_SUB;
      end else begin
        alu_a  = a_r;
        alu_b  = b_r;
        alu_op = alu_op_e'(op_r[2:0]);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_legal_exec)        state_nxt = EXEC;
          else if (cmd_op == OPC_MUL) state_nxt = MUL;
          else                       state_nxt = DONE;
        end
      end
      EXEC:    state_nxt = DONE;
      MUL:     if (!mul_first && (cnt == 8'h00)) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The first MUL cycle performs no add, so a response lands b+2 edges
  // after accept (b=0 -> E2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      cnt       <= '0;
      csticky   <= 1'b0;
      mul_first <= 1'b0;
      res_r     <= '0;
      flags_r   <= '0;
      err_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_r <= cmd_op;
            a_r  <= cmd_a;
            b_r  <= cmd_b;
            if (cmd_op == OPC_MUL) begin
              acc       <= '0;
              cnt       <= cmd_b;
              csticky   <= 1'b0;
              mul_first <= 1'b1;
            end else if (!cmd_legal_exec) begin
              res_r   <= '0;
              flags_r <= '0;
              err_r   <= 1'b1;
            end
          end
        end
        EXEC: begin
          res_r   <= alu_y;
          flags_r <= {alu_n, alu_z, alu_v, alu_c};
          err_r   <= 1'b0;
        end
        MUL: begin
          if (mul_first) begin
            mul_first <= 1'b0;
          end else if (cnt != 8'h00) begin
            acc     <= alu_y;
            csticky <= csticky | alu_c;
            cnt     <= cnt - 8'd1;
          end else begin
            res_r   <= acc;
            flags_r <= {acc[7], (acc == 8'h00), 1'b0, csticky};
            err_r   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign rsp_result = res_r;
  assign rsp_flags  = flags_r;
  assign rsp_err    = err_r;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed vectors, a behavioural reference model
// and literal expectations for the documented cases.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;
  logic       rsp_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic        pend = 1'b0;
  logic [12:0] exp_m = '0;

  alu_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference model: {err, n, z, v, c, result[7:0]} from plain arithmetic.
  function automatic logic [12:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int ai, bi, ub, sa, sb, r, s;
    logic c, v, arith;
    logic [7:0] res;
    ai = a; bi = b;
    sa = $signed(a); sb = $signed(b);
    ub = (op == 4'd1 || op == 4'd3) ? 1 : bi;
    if (op == 4'd1 || op == 4'd3) sb = 1;
    c = 1'b0; arith = 1'b0; r = 0; s = 0;
    case (op)
      4'd0, 4'd1: begin r = ai + ub; s = sa + sb; c = (r > 255); arith = 1'b1; end
      4'd2, 4'd3: begin r = ai - ub; s = sa - sb; c = (ai < ub); arith = 1'b1; end
      4'd4: r = ai & bi;
      4'd5: r = ai | bi;
      4'd6: r = ai ^ bi;
      4'd7: r = 255 - ai;
      4'd8: begin r = ai * bi; c = (r > 255); end
      4'd9: begin r = 0 - ai; s = 0 - sa; c = (ai > 0); arith = 1'b1; end
      default: return {1'b1, 4'b0000, 8'h00};
    endcase
    v = arith && ((s > 127) || (s < -128));
    res = r[7:0];
    return {1'b0, res[7], (res == 8'h00), v, c, res};
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [7:0] b);
    int bi;
    bi = b;
    return (op == 4'd8) ? bi + 2 : 1;
  endfunction

  // Every cycle: state decodes consistent, response equals the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", {31'd0, cmd_ready}, {31'd0, !busy});
      if (pend && rsp_valid) begin
        chk("rsp_result", {24'd0, rsp_result}, {24'd0, exp_m[7:0]});
        chk("rsp_flags",  {28'd0, rsp_flags},  {28'd0, exp_m[11:8]});
        chk("rsp_err",    {31'd0, rsp_err},    {31'd0, exp_m[12]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_rsp(input int lat);
    int k;
    logic got;
    k = 0; got = 1'b0;
    while (!got && k < 300) begin
      @(posedge clk); k++;
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("latency", k, lat);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    pend = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] gres, output logic [3:0] gfl, output logic gerr);
    @(negedge clk);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    exp_m = model(op, a, b);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pend = 1'b1;
    wait_rsp(latency(op, b));
    gres = rsp_result; gfl = rsp_flags; gerr = rsp_err;
    handshake();
  endtask

  task automatic pin(input string name, input logic [7:0] gres, input logic [3:0] gfl, input logic gerr,
                     input logic [7:0] eres, input logic [3:0] efl, input logic eerr);
    chk(name, {19'd0, gerr, gfl, gres}, {19'd0, eerr, efl, eres});
  endtask

  logic [7:0] r;
  logic [3:0] f;
  logic       e;
  int         seen;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_outputs",   {19'd0, rsp_err, rsp_flags, rsp_result}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Documented cases with literal expectations.
    run_op(4'd0, 8'h7F, 8'h01, r, f, e); pin("add_7f_01",  r, f, e, 8'h80, 4'b1010, 1'b0);
    run_op(4'd8, 8'h0D, 8'h0C, r, f, e); pin("mul_0d_0c",  r, f, e, 8'h9C, 4'b1000, 1'b0);
    run_op(4'd8, 8'h20, 8'h10, r, f, e); pin("mul_20_10",  r, f, e, 8'h00, 4'b0101, 1'b0);
    run_op(4'd8, 8'h55, 8'h00, r, f, e); pin("mul_55_00",  r, f, e, 8'h00, 4'b0100, 1'b0);
    run_op(4'd9, 8'h01, 8'h00, r, f, e); pin("neg_01",     r, f, e, 8'hFF, 4'b1001, 1'b0);
    run_op(4'd9, 8'h80, 8'h00, r, f, e); pin("neg_80",     r, f, e, 8'h80, 4'b1011, 1'b0);

    // Further vectors checked by the model.
    run_op(4'd1, 8'hFF, 8'h00, r, f, e); pin("inc_ff",     r, f, e, 8'h00, 4'b0101, 1'b0);
    run_op(4'd2, 8'h05, 8'h07, r, f, e); pin("sub_05_07",  r, f, e, 8'hFE, 4'b1001, 1'b0);
    run_op(4'd3, 8'h80, 8'h00, r, f, e); pin("dec_80",     r, f, e, 8'h7F, 4'b0010, 1'b0);
    run_op(4'd3, 8'h00, 8'h00, r, f, e);
    run_op(4'd5, 8'h0A, 8'h50, r, f, e);
    run_op(4'd7, 8'h5A, 8'h00, r, f, e); pin("not_5a",     r, f, e, 8'hA5, 4'b1000, 1'b0);
    run_op(4'd0, 8'h90, 8'h90, r, f, e);
    run_op(4'd8, 8'h02, 8'hFF, r, f, e); pin("mul_02_ff",  r, f, e, 8'hFE, 4'b1001, 1'b0);
    run_op(4'd8, 8'hFF, 8'h01, r, f, e);

    // AND with response stall and a command presented during the stall.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd4; cmd_a = 8'hF0; cmd_b = 8'h3C;
    exp_m = model(4'd4, 8'hF0, 8'h3C);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pend = 1'b1;
    wait_rsp(1);
    pin("and_f0_3c", rsp_result, rsp_flags, rsp_err, 8'h30, 4'b0000, 1'b0);
    cmd_valid = 1'b1; cmd_op = 4'd6; cmd_a = 8'h0F; cmd_b = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_result",    {24'd0, rsp_result}, 32'h30);
    end
    handshake();
    exp_m = model(4'd6, 8'h0F, 8'hFF);
    @(negedge clk);
    chk("release_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pend = 1'b1;
    chk("accept_after_release", {31'd0, busy}, 32'd1);
    wait_rsp(1);
    pin("xor_0f_ff", rsp_result, rsp_flags, rsp_err, 8'hF0, 4'b1000, 1'b0);
    handshake();

    // Illegal opcode, then reset during a MUL.
    run_op(4'hC, 8'h12, 8'h34, r, f, e); pin("illegal_c", r, f, e, 8'h00, 4'b0000, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 8'h03; cmd_b = 8'h40;
    exp_m = model(4'd8, 8'h03, 8'h40);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    pend = 1'b1;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    pend = 1'b0;
    #1;
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_busy",      {31'd0, busy},      32'd0);
    chk("midrst_outputs",   {19'd0, rsp_err, rsp_flags, rsp_result}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);

    // Normal operation resumes after reset.
    run_op(4'd8, 8'h03, 8'h04, r, f, e); pin("mul_03_04", r, f, e, 8'h0C, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
